// File: rtl/instr_fetch_responder.sv
// Instruction-fetch memory responder: a word array read at request accept, a fixed-latency
// pipeline, and a first-word-fall-through response FIFO with credit-based request flow control.
module instr_fetch_responder #(
  parameter int unsigned MEM_WORDS  = 256,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [63:0]                  req_addr,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [31:0]                  rsp_instr,
  output logic [63:0]                  rsp_addr,
  output logic [1:0]                   rsp_err,
  input  logic                         load_en,
  input  logic [$clog2(MEM_WORDS)-1:0] load_addr,
  input  logic [31:0]                  load_data,
  output logic [$clog2(FIFO_DEPTH):0]  outstanding
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("instr_fetch_responder: LATENCY must be in 1..4");
  end

  logic [31:0]   mem [MEM_WORDS];

  logic          accept;
  logic          push;
  logic          pop;
  logic [31:0]   rd_instr;
  logic [1:0]    rd_err;

  logic [LATENCY-1:0] pipe_valid_q;
  logic [31:0]        pipe_instr_q [LATENCY];
  logic [63:0]        pipe_addr_q  [LATENCY];
  logic [1:0]         pipe_err_q   [LATENCY];

  logic [31:0]   fifo_instr_q [FIFO_DEPTH];
  logic [63:0]   fifo_addr_q  [FIFO_DEPTH];
  logic [1:0]    fifo_err_q   [FIFO_DEPTH];
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] out_q;

  // Credit rule: every accepted request already owns a FIFO slot, so the pipeline never stalls.
  assign req_ready   = reset & ~load_en & (out_q < CW'(FIFO_DEPTH));
  assign accept      = req_valid & req_ready;
  assign push        = pipe_valid_q[LATENCY-1];
  assign rsp_valid   = (count_q != '0);
  assign pop         = rsp_valid & rsp_ready;
  assign outstanding = out_q;

  assign rsp_instr = rsp_valid ? fifo_instr_q[rptr_q] : '0;
  assign rsp_addr  = rsp_valid ? fifo_addr_q[rptr_q]  : '0;
  assign rsp_err   = rsp_valid ? fifo_err_q[rptr_q]   : '0;

  // Full 62-bit word-index compare so huge addresses never alias into the array.
  always_comb begin
    rd_err   = 2'b00;
    rd_instr = '0;
    if (req_addr[1:0] != 2'b00) begin
      rd_err = 2'b01;
    end else if (req_addr[63:2] >= 62'(MEM_WORDS)) begin
      rd_err = 2'b10;
    end else begin
      rd_instr = mem[req_addr[2 +: AW]];
    end
  end

  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    pipe_instr_q[0] <= rd_instr;
    pipe_addr_q[0]  <= req_addr;
    pipe_err_q[0]   <= rd_err;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_instr_q[i] <= pipe_instr_q[i-1];
      pipe_addr_q[i]  <= pipe_addr_q[i-1];
      pipe_err_q[i]   <= pipe_err_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr_q[wptr_q] <= pipe_instr_q[LATENCY-1];
      fifo_addr_q[wptr_q]  <= pipe_addr_q[LATENCY-1];
      fifo_err_q[wptr_q]   <= pipe_err_q[LATENCY-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_valid_q <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      out_q        <= '0;
    end else begin
      pipe_valid_q[0] <= accept;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
      end
      if (push) begin
        wptr_q <= wptr_q + PW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (!push && pop) begin
        count_q <= count_q - CW'(1);
      end
      if (accept && !pop) begin
        out_q <= out_q + CW'(1);
      end else if (!accept && pop) begin
        out_q <= out_q - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Scoreboard bench for instr_fetch_responder: expected responses are queued at accept from a
// reference word array and compared in order as the DUT pops them.
module tb_instr_fetch_responder;

  localparam int unsigned MEM_WORDS  = 256;
  localparam int unsigned LATENCY    = 2;
  localparam int unsigned FIFO_DEPTH = 4;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] addr;
    logic [1:0]  err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic [63:0] rsp_addr;
  logic [1:0]  rsp_err;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [31:0] load_data;
  logic [2:0]  outstanding;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_acc    = 0;
  logic thr      = 1'b0;
  rsp_t sb [$];
  logic [31:0] mdl_mem [MEM_WORDS];

  instr_fetch_responder #(
    .MEM_WORDS (MEM_WORDS),
    .LATENCY   (LATENCY),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_instr  (rsp_instr),
    .rsp_addr   (rsp_addr),
    .rsp_err    (rsp_err),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic rsp_t model(input logic [63:0] a);
    rsp_t r;
    r.addr  = a;
    r.instr = '0;
    r.err   = 2'b00;
    if (a[1:0] != 2'b00) r.err = 2'b01;
    else if (a[63:2] >= 62'(MEM_WORDS)) r.err = 2'b10;
    else r.instr = mdl_mem[a[9:2]];
    return r;
  endfunction

  // Monitor on the falling edge: handshakes seen here complete at the next rising edge.
  always @(negedge clk) begin
    rsp_t e;
    if (req_valid && req_ready) begin
      sb.push_back(model(req_addr));
      n_acc++;
    end
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check_eq("rsp_unexpected", rsp_valid, 1'b0);
      end else begin
        e = sb.pop_front();
        check_eq("rsp_instr", rsp_instr, e.instr);
        check_eq("rsp_addr", rsp_addr, e.addr);
        check_eq("rsp_err", rsp_err, e.err);
      end
    end
    if (load_en) mdl_mem[load_addr] = load_data;
  end

  task automatic load_word(input int idx, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = 8'(idx);
    load_data = d;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  task automatic send(input logic [63:0] a);
    logic ok;
    ok        = 1'b0;
    req_valid = 1'b1;
    req_addr  = a;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
      if (thr) rsp_ready = 1'($urandom_range(0, 1));
    end
    check_eq("send_accept", ok, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (thr) rsp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int n;
    n         = 0;
    rsp_ready = 1'b1;
    while ((sb.size() != 0 || outstanding != 0) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("drain_sb_empty", sb.size(), 0);
    check_eq("drain_outstanding", outstanding, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

  initial begin
    logic [97:0] head;
    int          base;
    logic [63:0] mix [10];
    mix = '{64'h0, 64'h4, 64'h8, 64'hC, 64'h6, 64'h400, 64'h3FC, 64'h1_0000_0000, 64'h4, 64'h0};

    reset     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    rsp_ready = 1'b0;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_req_ready", req_ready, 1'b0);
    check_eq("rst_rsp_valid", rsp_valid, 1'b0);
    check_eq("rst_outstanding", outstanding, 0);
    check_eq("rst_rsp_instr", rsp_instr, 0);
    check_eq("rst_rsp_addr", rsp_addr, 0);
    check_eq("rst_rsp_err", rsp_err, 0);
    reset = 1'b1;

    load_word(0, 32'h8B020041);
    load_word(1, 32'h91000421);
    load_word(2, 32'hDEADBEEF);
    load_word(3, 32'h00000013);
    load_word(255, 32'hCAFEF00D);

    // Back-to-back fetch and exact latency.
    rsp_ready = 1'b1;
    send(64'h0);
    send(64'h4);
    check_eq("lat_not_early", rsp_valid, 1'b0);
    @(posedge clk); #1;
    check_eq("lat_first_valid", rsp_valid, 1'b1);
    check_eq("lat_first_instr", rsp_instr, 32'h8B020041);
    @(posedge clk); #1;
    check_eq("lat_second_instr", rsp_instr, 32'h91000421);
    check_eq("lat_second_addr", rsp_addr, 64'h4);
    drain();

    // Error classification and range boundaries.
    send(64'h6);
    send(64'h400);
    send(64'hFFFF_FFFF_FFFF_FFFC);
    send(64'h1_0000_0000);
    send(64'h3FC);
    send(64'h8);
    drain();

    // Backpressure: credit limit, stable head, one pop frees exactly one accept.
    rsp_ready = 1'b0;
    base      = n_acc;
    req_valid = 1'b1;
    req_addr  = 64'h8;
    repeat (10) @(posedge clk);
    #1;
    check_eq("bp_outstanding", outstanding, 4);
    check_eq("bp_req_ready", req_ready, 1'b0);
    check_eq("bp_accepts", n_acc - base, 4);
    head = {rsp_instr, rsp_addr, rsp_err};
    repeat (3) @(posedge clk);
    #1;
    check_eq("bp_head_stable", {rsp_instr, rsp_addr, rsp_err}, head);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    base      = n_acc;
    repeat (5) @(posedge clk);
    #1;
    check_eq("bp_one_reaccept", n_acc - base, 1);
    check_eq("bp_outstanding_refill", outstanding, 4);
    req_valid = 1'b0;
    drain();

    // Simultaneous pop and accept with two entries held.
    rsp_ready = 1'b0;
    send(64'h8);
    send(64'hC);
    repeat (3) @(posedge clk);
    #1;
    check_eq("pa_pre_outstanding", outstanding, 2);
    req_valid = 1'b1;
    req_addr  = 64'h4;
    rsp_ready = 1'b1;
    @(negedge clk);
    check_eq("pa_req_ready", req_ready, 1'b1);
    check_eq("pa_rsp_valid", rsp_valid, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    check_eq("pa_outstanding", outstanding, 2);

    // Ordering under random consumer throttling.
    thr = 1'b1;
    foreach (mix[i]) send(mix[i]);
    thr = 1'b0;
    drain();

    // Load while an old read of the same word is in flight.
    send(64'h0);
    load_en   = 1'b1;
    load_addr = 8'd0;
    load_data = 32'h12345678;
    req_valid = 1'b1;
    req_addr  = 64'h0;
    @(negedge clk);
    check_eq("ld_req_ready", req_ready, 1'b0);
    @(posedge clk); #1;
    load_en   = 1'b0;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("ld_inflight_old", rsp_instr, 32'h8B020041);
    send(64'h0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("ld_new_instr", rsp_instr, 32'h12345678);
    drain();

    // Asynchronous reset mid-stream with three outstanding.
    rsp_ready = 1'b0;
    send(64'h0);
    send(64'h4);
    send(64'h8);
    check_eq("pre_rst_outstanding", outstanding, 3);
    #2;
    reset = 1'b0;
    #1;
    check_eq("arst_rsp_valid", rsp_valid, 1'b0);
    check_eq("arst_outstanding", outstanding, 0);
    check_eq("arst_req_ready", req_ready, 1'b0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset     = 1'b1;
    rsp_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check_eq("post_rst_no_stale", rsp_valid, 1'b0);
    check_eq("post_rst_outstanding", outstanding, 0);
    send(64'h4);
    send(64'h0);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_responder.md
Name: instr_fetch_responder

Overview:
- Memory-side responder for the instruction-fetch interface.
- Accepts fetch requests (64-bit byte address) from the PC/fetch stage over a valid/ready handshake and reads a 32-bit instruction word from an internal word array.
- Returns the instruction after a fixed pipeline latency through a response FIFO with backpressure and error flags.
- A load port writes program words into the array before or between runs.

Parameters:
MEM_WORDS, 256, number of 32-bit words in the array (power of 2)
LATENCY, 2, cycles from request accept to response FIFO push (1..4)
FIFO_DEPTH, 4, response FIFO entries (power of 2, >= 2)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low; 0 clears all control state
req_valid  input  1  fetch request present
req_ready  output  1  responder can accept a request this cycle
req_addr  input  64  byte address of the instruction
rsp_valid  output  1  response at FIFO head
rsp_ready  input  1  consumer takes the response
rsp_instr  output  32  instruction word (0 on error)
rsp_addr  output  64  echo of the request address
rsp_err  output  2  00 ok, 01 misaligned, 10 out of range
load_en  input  1  write load_data into the array this cycle
load_addr  input  $clog2(MEM_WORDS)  word index for the load
load_data  input  32  word to write
outstanding  output  $clog2(FIFO_DEPTH)+1  requests in pipeline plus FIFO

Behaviour:
- Reset (reset=0, async):
  - Pipeline valid bits, FIFO pointers and count, and outstanding are cleared.
  - req_ready=0 while reset is asserted. rsp_valid=0, rsp_instr=0, rsp_addr=0, rsp_err=0.
  - Array contents are not reset.
  - Requests in flight at reset assertion are discarded and never returned.
- Accept:
  - Occurs when req_valid & req_ready at a rising edge.
  - req_ready = reset & !load_en & (outstanding < FIFO_DEPTH).
  - This credit rule guarantees every pipeline entry has a FIFO slot, so the pipeline never stalls.
- Read and error classification at accept, in priority order:
  - req_addr[1:0] != 0: err=01, instr=0.
  - Else req_addr[63:2] >= MEM_WORDS: err=10, instr=0. The full 64-bit compare is used; no truncation or wrap.
  - Else err=00, instr = array[req_addr[2+:$clog2(MEM_WORDS)]].
- Pipeline:
  - {instr, addr, err, valid} shift through LATENCY stages and are pushed into the FIFO at the edge ending stage LATENCY.
  - A request accepted at edge N has rsp_valid=1 after edge N+LATENCY when the FIFO was empty.
- FIFO:
  - First-word-fall-through; rsp_* reflect the head entry whenever rsp_valid=1.
  - Pop on rsp_valid & rsp_ready.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - rsp_* hold stable while rsp_valid=1 and rsp_ready=0.
- Outstanding counter: +1 on accept, -1 on pop, unchanged when both occur.
- Ordering: responses are returned strictly in request order.
- Load:
  - load_en writes array[load_addr] at the edge.
  - req_ready is 0 in that cycle, so a read and a write are never performed together.
  - Responses already in flight keep the values read at accept.
- Unused parameter range (LATENCY outside 1..4) is a synthesis-time error.

Test Plan:
- Load words 0x8B020041 at index 0 and 0x91000421 at index 1; request 0x0 then 0x4 back-to-back, rsp_ready=1 -> rsp_instr 0x8B020041 at edge N+2, then 0x91000421 at edge N+3, both err=00, rsp_addr echoed.
- Request 0x6 -> err=01, instr=0. Request 0x400 with MEM_WORDS=256 -> err=10, instr=0. Request 0xFFFF_FFFF_FFFF_FFFC -> err=10.
- Hold rsp_ready=0 and issue continuous requests:
  - req_ready drops after 4 accepts; outstanding=4.
  - Head response stays stable.
  - Raising rsp_ready for one cycle pops one entry and re-enables exactly one accept.
- With the FIFO holding 2 entries, pop and accept in the same cycle -> outstanding stays 2; ordering is preserved over 10 mixed-throttle requests against a scoreboard.
- Assert load_en to rewrite index 0 to 0x12345678 while the old read of index 0 is in flight:
  - req_ready=0 during load_en.
  - The in-flight response returns 0x8B020041.
  - The next request to 0x0 returns 0x12345678.
- Pulse reset low mid-stream with 3 outstanding -> rsp_valid=0 and outstanding=0 immediately (asynchronous); array contents survive; no stale responses after release.
